// File: rtl/extbus_pkg.sv
// Shared types for the external bus master: sequencer states, queued request word, bus width.
// Latency/backpressure are properties of the modules that import this package.
package extbus_pkg;

    localparam int EXTBUS_W  = 72;
    localparam int EXTBUS_AW = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAP  = 3'd3,
        RSP     = 3'd4
    } extbus_state_t;

    typedef struct packed {
        logic                 write;
        logic [EXTBUS_AW-1:0] addr;
        logic [EXTBUS_W-1:0]  data;
    } extbus_req_t;

    function automatic logic drives_bus(input extbus_state_t s);
        return (s == WR) || (s == RD_ADDR);
    endfunction

endpackage

// File: rtl/extbus_fifo.sv
// Circular request FIFO, power-of-two DEPTH; head visible combinationally, push lands next cycle.
// Backpressure: push ignored at full, pop ignored at empty; owner gates with o_count.
module extbus_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  T                         i_din,
    input  logic                     i_pop,
    output T                         o_dout,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push = i_push && (r_count != FULL_CNT);
    assign w_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/extbus_master.sv
// CPU-to-external-bus master: write bus_en 2 cycles after accept; read rsp_valid 2 cycles after its bus_en.
// Backpressure: req_ready low while the FIFO is full; a held response (RSP) blocks further pops.
module extbus_master
    import extbus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_addr,
    input  logic [EXTBUS_W-1:0]  req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [EXTBUS_W-1:0]  rsp_data,
    output logic [1:0]           bus_addr,
    output logic                 bus_en,
    output logic                 bus_we,
    output logic [EXTBUS_W-1:0]  bus_dout,
    input  logic [EXTBUS_W-1:0]  bus_din,
    output logic                 busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    extbus_state_t          r_state;
    extbus_state_t          w_next_state;
    extbus_req_t            w_push_req;
    extbus_req_t            w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic [CW-1:0]          w_count;
    logic [1:0]             r_bus_addr;
    logic [EXTBUS_W-1:0]    r_bus_dout;
    logic [EXTBUS_W-1:0]    r_rsp_data;

    assign req_ready  = (w_count != CW'(DEPTH));
    assign w_push     = req_valid && req_ready;
    assign w_push_req = '{write: req_write, addr: req_addr, data: req_wdata};

    extbus_fifo #(
        .DEPTH (DEPTH),
        .T     (extbus_req_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_push_req),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pops happen only from IDLE, so a pending response keeps later requests queued in order.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        bus_en       = 1'b0;
        bus_we       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = w_head.write ? WR : RD_ADDR;
                end
            end
            WR: begin
                bus_en       = 1'b1;
                bus_we       = 1'b1;
                w_next_state = IDLE;
            end
            RD_ADDR: begin
                bus_en       = 1'b1;
                w_next_state = RD_CAP;
            end
            RD_CAP: begin
                w_next_state = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // bus_din is the port's registered output, valid during RD_CAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_addr <= '0;
            r_bus_dout <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_pop) begin
                r_bus_addr <= w_head.addr;
                r_bus_dout <= w_head.data;
            end
            if (r_state == RD_CAP) begin
                r_rsp_data <= bus_din;
            end
        end
    end

    assign bus_addr  = r_bus_addr;
    assign bus_dout  = r_bus_dout;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = (r_state == RSP);
    assign busy      = !w_empty || (r_state != IDLE);

    assert property (@(posedge clk) disable iff (reset)
        bus_en |-> drives_bus(r_state));

    assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data)));

endmodule

// File: tb/tb_extbus_master.sv
// Bench for extbus_master: directed vector table, multi-cycle corner sequences and randomized traffic
// checked against a queue-based model of the bus port and response stream.
module tb_extbus_master;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_addr = '0;
    logic [71:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [71:0] rsp_data;
    logic [1:0]  bus_addr;
    logic        bus_en;
    logic        bus_we;
    logic [71:0] bus_dout;
    logic [71:0] bus_din;
    logic        busy;

    always #5 clk = ~clk;

    extbus_master #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .bus_addr  (bus_addr),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_dout  (bus_dout),
        .bus_din   (bus_din),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [71:0] init_word(input int a);
        case (a)
            0:       return 72'hC0_0C0C0C0C0C0C0C0C;
            1:       return 72'h5A_FEDCBA9876543210;
            2:       return 72'h22_2222222222222222;
            default: return 72'h33_3333333333333333;
        endcase
    endfunction

    // Bus port: synchronous memory with a registered read output.
    logic [71:0] bus_mem [4];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) bus_mem[i] <= init_word(i);
            bus_din <= '0;
        end else begin
            if (bus_en && bus_we) bus_mem[bus_addr] <= bus_dout;
            if (bus_en && !bus_we) bus_din <= bus_mem[bus_addr];
        end
    end

    // Reference model: requests execute in acceptance order against a 4-word memory.
    typedef struct {
        logic        write;
        logic [1:0]  addr;
        logic [71:0] data;
    } op_t;

    logic [71:0] model_mem [4];
    op_t         exp_bus[$];
    logic [71:0] exp_rsp[$];
    int          pulse_cyc[$];

    task automatic model_reset();
        exp_bus.delete();
        exp_rsp.delete();
        for (int i = 0; i < 4; i++) model_mem[i] = init_word(i);
    endtask

    task automatic model_accept(input logic w, input logic [1:0] a, input logic [71:0] d);
        op_t op;
        op.write = w;
        op.addr  = a;
        op.data  = d;
        exp_bus.push_back(op);
        if (w) model_mem[a] = d;
        else   exp_rsp.push_back(model_mem[a]);
    endtask

    task automatic send(input logic w, input logic [1:0] a, input logic [71:0] d);
        bit ok = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1;
                model_accept(w, a, d);
            end else begin
                @(negedge clk);
            end
        end
        chk("req_accepted", 72'(ok), 72'(1));
        #1 req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit idle = 0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(negedge clk);
            if (exp_bus.size() == 0 && exp_rsp.size() == 0 && !busy) idle = 1;
        end
        chk({tag, "_drained"}, 72'(idle), 72'(1));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req_ready"}, 72'(req_ready), 72'(1));
        chk({tag, "_rsp_valid"}, 72'(rsp_valid), 72'(0));
        chk({tag, "_busy"},      72'(busy),      72'(0));
        chk({tag, "_bus_en"},    72'(bus_en),    72'(0));
        chk({tag, "_bus_we"},    72'(bus_we),    72'(0));
        chk({tag, "_bus_addr"},  72'(bus_addr),  72'(0));
        chk({tag, "_bus_dout"},  bus_dout,       72'(0));
        chk({tag, "_rsp_data"},  rsp_data,       72'(0));
    endtask

    task automatic check_spacing(input string tag, input int n);
        chk({tag, "_pulse_count"}, 72'(pulse_cyc.size()), 72'(n));
        for (int i = 1; i < pulse_cyc.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), 72'(pulse_cyc[i] - pulse_cyc[i-1]), 72'(2));
    endtask

    // Continuous port monitor against the model queues.
    bit          mon_en = 0;
    logic        prev_en = 1'b0;
    logic        prev_hold = 1'b0;
    logic [71:0] prev_rsp = '0;
    op_t         mon_op;

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            prev_en   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (bus_we) chk("bus_we_implies_en", 72'(bus_en), 72'(1));
            if (bus_en) begin
                pulse_cyc.push_back(cyc);
                chk("bus_en_one_cycle", 72'(prev_en), 72'(0));
                chk("bus_op_pending", 72'(exp_bus.size() > 0), 72'(1));
                if (exp_bus.size() > 0) begin
                    mon_op = exp_bus.pop_front();
                    chk("bus_we", 72'(bus_we), 72'(mon_op.write));
                    chk("bus_addr", 72'(bus_addr), 72'(mon_op.addr));
                    if (mon_op.write) chk("bus_dout", bus_dout, mon_op.data);
                end
            end
            if (prev_hold) begin
                chk("rsp_valid_held", 72'(rsp_valid), 72'(1));
                chk("rsp_data_stable", rsp_data, prev_rsp);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", 72'(exp_rsp.size() > 0), 72'(1));
                if (exp_rsp.size() > 0) chk("rsp_data", rsp_data, exp_rsp.pop_front());
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = rsp_data;
            prev_en   = bus_en;
        end
    end

    typedef struct {
        logic        write;
        logic [1:0]  addr;
        logic [71:0] data;
        logic [71:0] rsp;
    } vec_t;

    vec_t        vecs[6];
    int          en_cnt, en_at, rsp_at;
    logic        we_seen;
    logic [1:0]  addr_seen;
    logic [71:0] dout_seen, rsp_seen, hold_exp;
    bit          done;

    initial begin
        vecs[0] = '{1'b1, 2'd2, 72'hAB_0123456789ABCDEF, 72'h0};
        vecs[1] = '{1'b0, 2'd1, 72'h0, 72'h5A_FEDCBA9876543210};
        vecs[2] = '{1'b0, 2'd2, 72'h0, 72'hAB_0123456789ABCDEF};
        vecs[3] = '{1'b1, 2'd1, 72'h11_00FF00FF00FF00FF, 72'h0};
        vecs[4] = '{1'b0, 2'd1, 72'h0, 72'h11_00FF00FF00FF00FF};
        vecs[5] = '{1'b0, 2'd3, 72'h0, 72'h33_3333333333333333};

        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset_checks("reset");
        mon_en = 1;

        // Single transactions on an idle block: exact cycle positions of bus_en and rsp_valid.
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].write, vecs[i].addr, vecs[i].data);
            en_cnt = 0; en_at = -1; rsp_at = -1;
            we_seen = 1'b0; addr_seen = '0; dout_seen = '0; rsp_seen = '0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k == 1) chk($sformatf("vec%0d_busy", i), 72'(busy), 72'(1));
                if (bus_en) begin
                    en_cnt++; en_at = k; we_seen = bus_we; addr_seen = bus_addr; dout_seen = bus_dout;
                end
                if (rsp_valid && rsp_at < 0) begin
                    rsp_at = k; rsp_seen = rsp_data;
                end
            end
            chk($sformatf("vec%0d_en_count", i), 72'(en_cnt), 72'(1));
            chk($sformatf("vec%0d_en_latency", i), 72'(en_at), 72'(2));
            chk($sformatf("vec%0d_we", i), 72'(we_seen), 72'(vecs[i].write));
            chk($sformatf("vec%0d_addr", i), 72'(addr_seen), 72'(vecs[i].addr));
            if (vecs[i].write) begin
                chk($sformatf("vec%0d_dout", i), dout_seen, vecs[i].data);
                chk($sformatf("vec%0d_no_rsp", i), 72'(rsp_at < 0), 72'(1));
            end else begin
                chk($sformatf("vec%0d_rsp_latency", i), 72'(rsp_at), 72'(4));
                chk($sformatf("vec%0d_rsp_data", i), rsp_seen, vecs[i].rsp);
            end
            chk($sformatf("vec%0d_idle", i), 72'(busy), 72'(0));
        end

        // Held response: FIFO fills behind it and nothing is popped.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        hold_exp = model_mem[0];
        send(1'b0, 2'd0, 72'h0);
        send(1'b0, 2'd1, 72'h0);
        send(1'b0, 2'd2, 72'h0);
        @(negedge clk);
        chk("hold_full_ready", 72'(req_ready), 72'(0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_ready", k), 72'(req_ready), 72'(0));
            chk($sformatf("hold%0d_rsp_valid", k), 72'(rsp_valid), 72'(1));
            chk($sformatf("hold%0d_bus_en", k), 72'(bus_en), 72'(0));
            chk($sformatf("hold%0d_rsp_data", k), rsp_data, hold_exp);
        end
        drain("hold");

        // Back-to-back writes to every address.
        pulse_cyc.delete();
        for (int i = 0; i < 4; i++) send(1'b1, 2'(i), {8'(i + 8'hA0), 64'h1111_0000_0000_0000 + 64'(i)});
        drain("b2b");
        check_spacing("b2b", 4);

        // Push and pop on the same edge with one entry queued, repeatedly across pointer wraps.
        pulse_cyc.delete();
        send(1'b1, 2'd0, 72'hE0_0000000000000000);
        send(1'b1, 2'd1, 72'hE1_0000000000000001);
        for (int i = 2; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("pp%0d_ready", i), 72'(req_ready), 72'(1));
            send(1'b1, 2'(i % 4), {8'(8'hE0 + i), 64'(i)});
        end
        drain("pp");
        check_spacing("pp", 10);

        // Reset during RD_CAP with one request still queued.
        send(1'b0, 2'd1, 72'h0);
        send(1'b1, 2'd3, 72'hDD_DDDDDDDDDDDDDDDD);
        @(negedge clk);
        chk("rst_rd_addr_en", 72'(bus_en), 72'(1));
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_busy", 72'(busy), 72'(1));
        chk("rst_pre_en", 72'(bus_en), 72'(0));
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset_checks("midrst");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_bus_en", 72'(bus_en), 72'(0));
        chk("post_rst_busy", 72'(busy), 72'(0));

        // Randomized traffic with random consumer backpressure.
        done = 0;
        fork
            begin
                logic        w;
                logic [1:0]  a;
                logic [71:0] d;
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    w = 1'($urandom_range(0, 1));
                    a = 2'($urandom_range(0, 3));
                    d[31:0]  = $urandom;
                    d[63:32] = $urandom;
                    d[71:64] = 8'($urandom);
                    send(w, a, d);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain("random");
        chk("random_bus_queue_empty", 72'(exp_bus.size()), 72'(0));
        chk("random_rsp_queue_empty", 72'(exp_rsp.size()), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/extbus_master.md
EXTBUS_MASTER -- requirements
Module: extbus_master

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 2, meaning request FIFO entries; it SHALL be a power of two, 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit, meaning a CPU-side request is offered.
REQ-005 The block SHALL have port req_ready, output, 1 bit, meaning the request FIFO is not full.
REQ-006 The block SHALL have port req_write, input, 1 bit, meaning 1 = write and 0 = read.
REQ-007 The block SHALL have port req_addr, input, 2 bits, meaning the external bus word address.
REQ-008 The block SHALL have port req_wdata, input, 72 bits, meaning the write word: data 63:0 and tag 71:64.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit, meaning read data is available.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit, meaning the consumer accepts the response.
REQ-011 The block SHALL have port rsp_data, output, 72 bits, meaning the captured read word.
REQ-012 The block SHALL have port bus_addr, output, 2 bits, meaning the external bus port address.
REQ-013 The block SHALL have port bus_en, output, 1 bit, meaning the port enable, active high.
REQ-014 The block SHALL have port bus_we, output, 1 bit, meaning the port write enable, active high.
REQ-015 The block SHALL have port bus_dout, output, 72 bits, meaning data driven to the bus port.
REQ-016 The block SHALL have port bus_din, input, 72 bits, meaning registered read data from the bus port.
REQ-017 The block SHALL have port busy, output, 1 bit, meaning the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-018 A request SHALL be accepted on a cycle with req_valid & req_ready and pushed with {write, addr, wdata}.
REQ-019 The FIFO SHALL be circular with wrapping pointers and an occupancy count of log2(DEPTH)+1 bits; req_ready SHALL be (count != DEPTH).
REQ-020 A simultaneous push and pop SHALL leave count unchanged; a push while full SHALL be impossible because req_ready = 0.
REQ-021 The FSM states SHALL be IDLE, WR, RD_ADDR, RD_CAP and RSP.
REQ-022 In IDLE, a non-empty FIFO SHALL pop its head into registered bus_addr and bus_dout, then go to WR for a write or RD_ADDR for a read.
REQ-023 WR SHALL last 1 cycle with bus_en = 1 and bus_we = 1, then return to IDLE; write latency from acceptance into an empty FIFO SHALL be 2 cycles to the bus_en pulse.
REQ-024 RD_ADDR SHALL last 1 cycle with bus_en = 1 and bus_we = 0.
REQ-025 RD_CAP SHALL last 1 cycle with bus_en = 0 and SHALL load bus_din into rsp_data at its end, then go to RSP.
REQ-026 In RSP, rsp_valid SHALL be 1 and rsp_data SHALL be stable until rsp_valid & rsp_ready, which SHALL return the FSM to IDLE.
REQ-027 While in RSP, the FSM SHALL NOT pop the FIFO, so responses stay in request order.
REQ-028 bus_en and bus_we SHALL be 0 in every state other than those in REQ-023 and REQ-024.
REQ-029 Back-to-back writes SHALL issue one bus_en pulse every 2 cycles (IDLE, WR).
REQ-030 bus_addr and bus_dout SHALL hold their last values when idle.

Reset
REQ-031 On reset, the FSM SHALL go to IDLE and count and both pointers SHALL be 0.
REQ-032 On reset, bus_en, bus_we, rsp_valid and busy SHALL be 0, and bus_addr, bus_dout and rsp_data SHALL be 0.
REQ-033 Reset mid-transfer SHALL abandon the FIFO contents and any pending response, with no bus_en pulse in the following cycle.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (extbus_state_t), the request struct (extbus_req_t: write, addr[1:0], data[71:0]) and the constant EXTBUS_W = 72.
REQ-035 The request FIFO SHALL be a single sub-module, extbus_fifo, parameterised by DEPTH and element type; the FSM SHALL stay in the top module.

Verification
REQ-036 Stimulus: after reset, write addr 2 with data 72'hAB_0123456789ABCDEF. Required: bus_en = bus_we = 1 for exactly one cycle, with bus_addr = 2 and bus_dout equal to that value.
REQ-037 Stimulus: read addr 1 with bus_din = 72'h5A_FEDCBA9876543210 and rsp_ready = 1. Required: bus_en = 1, bus_we = 0 for one cycle, and rsp_valid with that data 2 cycles after the bus_en pulse.
REQ-038 Stimulus: DEPTH = 2, hold rsp_ready = 0 and issue 3 reads. Required: req_ready = 0 after the FIFO fills, the FIFO is not popped, and rsp_data stays stable until rsp_ready rises.
REQ-039 Stimulus: 4 back-to-back writes to addr 0..3. Required: bus_en pulses 2 cycles apart, addresses in order, no gaps other than IDLE.
REQ-040 Stimulus: assert reset during RD_CAP with 1 entry queued. Required: next cycle rsp_valid = 0, busy = 0, req_ready = 1, and no bus activity.
REQ-041 Stimulus: push and pop in the same cycle with 1 entry queued. Required: count stays 1 and the pointer wrap is correct over 10 cycles.
